// File: rtl/run_length_detector.sv
// Run-length detector for a multi-bit symbol stream.
// The input sample is registered first. The registered sample is then compared
// against the symbol of the current run. Two Mealy flags report when the run,
// including that sample, has reached TH_X or TH_Y symbols.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no sample accepted since reset; the next valid sample starts a run
//   RUN   | sym/cnt describe the run ending at the last accepted sample
//
// Parameter legality: 2 <= TH_X <= TH_Y <= 2**CNT_W-1.
module run_length_detector #(
  parameter int DATA_W = 1,
  parameter int CNT_W  = 4,
  parameter int TH_X   = 2,
  parameter int TH_Y   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              cen,
  input  logic              clr,
  output logic              doutx,
  output logic              douty,
  output logic [CNT_W-1:0]  run_len
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TH_X_L  = CNT_W'(TH_X);
  localparam logic [CNT_W-1:0] TH_Y_L  = CNT_W'(TH_Y);

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  din_ff, sym;
  logic               cen_ff, clr_ff, v_ff;
  logic [CNT_W-1:0]   cnt, len_now;

  // Input sampling stage. v_ff marks that the stage holds a real sample,
  // so the all-zero contents left by reset are never counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      din_ff <= '0;
      cen_ff <= 1'b0;
      clr_ff <= 1'b0;
      v_ff   <= 1'b0;
    end else begin
      din_ff <= din;
      cen_ff <= cen;
      clr_ff <= clr;
      v_ff   <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: the first valid sample enters RUN; only reset leaves it.
  always_comb begin
    state_nxt = state;
    if (v_ff) state_nxt = RUN;
  end

  // Length of the run including the registered sample. The length saturates
  // at CNT_MAX. A clear wins over a symbol match.
  always_comb begin
    len_now = '0;
    if (v_ff) begin
      if (state == IDLE || clr_ff || din_ff != sym)
        len_now = CNT_W'(1);
      else if (cnt == CNT_MAX)
        len_now = CNT_MAX;
      else
        len_now = cnt + CNT_W'(1);
    end
  end

  // Run symbol and count. Counting continues while cen is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      sym <= '0;
      cnt <= '0;
    end else if (v_ff) begin
      sym <= din_ff;
      cnt <= len_now;
    end
  end

  // Mealy outputs. They depend only on registers, so there is no path from
  // an input straight to an output.
  always_comb begin
    doutx = cen_ff && (len_now >= TH_X_L);
    douty = cen_ff && (len_now >= TH_Y_L);
  end

  assign run_len = cnt;

endmodule

// File: tb/tb_run_length_detector.sv
// Scoreboard bench for run_length_detector. dut0 uses the default parameters.
// dut1 uses DATA_W=4, CNT_W=3, TH_X=3, TH_Y=5.
// Each stimulus step pushes its expected response, worked out by hand. An
// independent monitor per DUT pops one entry each cycle and compares.
// An entry holds the flags for the sample captured at the next edge and
// run_len as of the previous sample.
module tb_run_length_detector;

  typedef struct {
    logic       x;
    logic       y;
    logic [3:0] rl;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset0 = 1'b1, reset1 = 1'b1;
  logic [0:0] din0 = '0;
  logic [3:0] din1 = '0;
  logic       cen0 = 1'b0, cen1 = 1'b0, clr0 = 1'b0, clr1 = 1'b0;
  logic       doutx0, douty0, doutx1, douty1;
  logic [3:0] run_len0;
  logic [2:0] run_len1;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  bit   done0 = 1'b0, done1 = 1'b0;

  always #5 clk = ~clk;

  run_length_detector dut0 (
    .clk(clk), .reset(reset0), .din(din0), .cen(cen0), .clr(clr0),
    .doutx(doutx0), .douty(douty0), .run_len(run_len0)
  );

  run_length_detector #(.DATA_W(4), .CNT_W(3), .TH_X(3), .TH_Y(5)) dut1 (
    .clk(clk), .reset(reset1), .din(din1), .cen(cen1), .clr(clr1),
    .doutx(doutx1), .douty(douty1), .run_len(run_len1)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Stimulus helpers: they change inputs only at negedge.
  task automatic step0(input logic d, input logic c, input logic cl,
                       input logic x, input logic y, input int rl);
    @(negedge clk);
    reset0 = 1'b0; din0 = d; cen0 = c; clr0 = cl;
    q0.push_back('{x, y, 4'(rl)});
  endtask

  task automatic rst0();
    @(negedge clk);
    reset0 = 1'b1; din0 = 1'b1; cen0 = 1'b1; clr0 = 1'b0;
    q0.push_back('{1'b0, 1'b0, 4'd0});
  endtask

  task automatic step1(input logic [3:0] d, input logic c,
                       input logic x, input logic y, input int rl);
    @(negedge clk);
    reset1 = 1'b0; din1 = d; cen1 = c; clr1 = 1'b0;
    q1.push_back('{x, y, 4'(rl)});
  endtask

  // Monitors: pop an entry when the sample it describes is captured, and
  // compare half a cycle later.
  initial begin : mon0
    exp_t e;
    forever begin
      @(posedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        @(negedge clk);
        check("dut0 doutx",   int'(doutx0),   int'(e.x));
        check("dut0 douty",   int'(douty0),   int'(e.y));
        check("dut0 run_len", int'(run_len0), int'(e.rl));
      end
    end
  end

  initial begin : mon1
    exp_t e;
    forever begin
      @(posedge clk);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        @(negedge clk);
        check("dut1 doutx",   int'(doutx1),   int'(e.x));
        check("dut1 douty",   int'(douty1),   int'(e.y));
        check("dut1 run_len", int'({1'b0, run_len1}), int'(e.rl));
      end
    end
  end

  // Default configuration.
  initial begin : stim0
    rst0(); rst0();
    // All-zero stream; the trailing mismatch sample exposes run_len=5.
    step0(0,1,0, 0,0,0); step0(0,1,0, 1,0,1); step0(0,1,0, 1,1,2);
    step0(0,1,0, 1,1,3); step0(0,1,0, 1,1,4); step0(1,0,0, 0,0,5);
    // Alternating stream 1,1,0,1,1,1.
    rst0();
    step0(1,1,0, 0,0,0); step0(1,1,0, 1,0,1); step0(0,1,0, 0,0,2);
    step0(1,1,0, 0,0,1); step0(1,1,0, 1,0,1); step0(1,1,0, 1,1,2);
    // Enable masking: the run keeps counting while cen is low.
    rst0();
    step0(1,0,0, 0,0,0); step0(1,0,0, 0,0,1); step0(1,0,0, 0,0,2);
    step0(1,1,0, 1,1,3);
    // Restart via clr on the 4th sample, then run on to length 6.
    rst0();
    step0(0,1,0, 0,0,0); step0(0,1,0, 1,0,1); step0(0,1,0, 1,1,2);
    step0(0,1,1, 0,0,3); step0(0,1,0, 1,0,1); step0(0,1,0, 1,1,2);
    step0(0,1,0, 1,1,3); step0(0,1,0, 1,1,4); step0(0,1,0, 1,1,5);
    // Reset mid-run. The first sample afterwards is a fresh run of length 1.
    rst0();
    step0(0,1,0, 0,0,0); step0(0,1,0, 1,0,1); step0(0,1,0, 1,1,2);
    @(negedge clk); cen0 = 1'b0;
    repeat (3) @(negedge clk);
    done0 = 1'b1;
  end

  // Wide symbols with a 3-bit counter that saturates at 7.
  initial begin : stim1
    @(negedge clk); reset1 = 1'b1; q1.push_back('{1'b0, 1'b0, 4'd0});
    step1(4'hA,1, 0,0,0); step1(4'hA,1, 0,0,1); step1(4'hA,1, 1,0,2);
    step1(4'hA,1, 1,0,3); step1(4'hA,1, 1,1,4); step1(4'hA,1, 1,1,5);
    step1(4'hA,1, 1,1,6); step1(4'hA,1, 1,1,7); step1(4'hA,1, 1,1,7);
    step1(4'hA,1, 1,1,7); step1(4'hA,0, 0,0,7); step1(4'h5,1, 0,0,7);
    @(negedge clk); cen1 = 1'b0;
    repeat (3) @(negedge clk);
    done1 = 1'b1;
  end

  initial begin : finish_ctl
    fork
      wait (done0 && done1);
      #100000;
    join_any
    if (!(done0 && done1)) begin
      errors++;
      $display("FAIL timeout: stimulus done0=%0d done1=%0d, expected 1 1", done0, done1);
    end
    checks++;
    if (q0.size() + q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", q0.size() + q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
